sat_search_engine: RTL and testbench

Programmable brute-force CNF satisfiability search engine, the sequential successor to the fixed two-level clause PLA. A host loads up to M clauses over N variables through a write port. The engine then enumerates assignments 0 to 2^N−1 and evaluates one assignment per clock. It stops on each satisfying assignment, and the host can resume the search to enumerate further solutions.

---
 rtl/sat_search_engine.sv | 101 ++++++++++
 tb/tb_sat_search_engine.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sat_search_engine.sv
// sat_search_engine: brute-force CNF search over N variables with M programmable clauses,
// one assignment evaluated per clock, stopping on each solution until resumed.
module sat_search_engine #(
    parameter int N  = 10,
    parameter int M  = 16,
    parameter int AW = $clog2(M)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_pos,
    input  logic [N-1:0]  wr_neg,
    input  logic          start,
    input  logic          resume,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          sat,
    output logic          exhausted,
    output logic [N-1:0]  assignment
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] FOUND  = 2'd2;

    logic [1:0]   state;
    logic [N-1:0] x;
    logic [N-1:0] pos [M];
    logic [N-1:0] neg [M];
    logic [M-1:0] clause_ok;
    logic         cnf;

    // an all-zero slot is disabled and must not veto the conjunction
    always_comb begin
        clause_ok = '0;
        for (int c = 0; c < M; c++)
            clause_ok[c] = (pos[c] == '0 && neg[c] == '0) || |(pos[c] & x) || |(neg[c] & ~x);
    end

    assign cnf      = &clause_ok;
    assign wr_ready = state == IDLE;
    assign busy     = state == SEARCH;
    assign sat      = state == FOUND;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < M; c++) begin
                pos[c] <= '0;
                neg[c] <= '0;
            end
        end else if (wr_valid && state == IDLE && {1'b0, wr_addr} < (AW+1)'(M)) begin
            pos[wr_addr] <= wr_pos;
            neg[wr_addr] <= wr_neg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            x          <= '0;
            done       <= 1'b0;
            exhausted  <= 1'b0;
            assignment <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                exhausted <= 1'b0;
            end else if (start) begin
                state     <= SEARCH;
                x         <= '0;
                exhausted <= 1'b0;
            end else if (state == SEARCH) begin
                if (cnf) begin
                    state      <= FOUND;
                    assignment <= x;
                    done       <= 1'b1;
                end else if (&x) begin
                    state      <= IDLE;
                    exhausted  <= 1'b1;
                    assignment <= '0;
                    done       <= 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end else if (state == FOUND && resume) begin
                if (&assignment) begin
                    state      <= IDLE;
                    exhausted  <= 1'b1;
                    assignment <= '0;
                    done       <= 1'b1;
                end else begin
                    state <= SEARCH;
                    x     <= assignment + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sat_search_engine.sv
// tb_sat_search_engine: directed scenarios for sat_search_engine (N=4, M=4) with a
// reference clause model feeding an expected-result queue.
module tb_sat_search_engine;
    localparam int N  = 4;
    localparam int M  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic          start = 1'b0;
    logic          resume = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [N-1:0]  wr_pos = '0;
    logic [N-1:0]  wr_neg = '0;
    logic          wr_ready, busy, done, sat, exhausted;
    logic [N-1:0]  assignment;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    logic [N-1:0] mpos [M];
    logic [N-1:0] mneg [M];

    typedef struct {
        int           lat;
        logic         sat;
        logic         exh;
        logic [N-1:0] asg;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    sat_search_engine #(.N(N), .M(M), .AW(AW)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_pos(wr_pos), .wr_neg(wr_neg),
        .start(start), .resume(resume), .abort(abort),
        .busy(busy), .done(done), .sat(sat), .exhausted(exhausted),
        .assignment(assignment)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // first satisfying x in [from, 15]; latency counts edges after the launching edge
    function automatic exp_t model(input int from);
        exp_t e;
        logic [N-1:0] xv;
        logic ok;
        e.lat = 16 - from; e.sat = 1'b0; e.exh = 1'b1; e.asg = '0;
        for (int v = from; v < 16; v++) begin
            xv = v[N-1:0];
            ok = 1'b1;
            for (int c = 0; c < M; c++)
                if ((mpos[c] | mneg[c]) != '0 && (mpos[c] & xv) == '0 && (mneg[c] & ~xv) == '0)
                    ok = 1'b0;
            if (ok) begin
                e.lat = v - from + 1; e.sat = 1'b1; e.exh = 1'b0; e.asg = xv;
                return e;
            end
        end
        return e;
    endfunction

    task automatic write_clause(input int a, input logic [N-1:0] p, input logic [N-1:0] n);
        wr_valid = 1'b1; wr_addr = a[AW-1:0]; wr_pos = p; wr_neg = n;
        mpos[a] = p; mneg[a] = n;
        tick;
        wr_valid = 1'b0;
    endtask

    task automatic go(input logic s, input logic r, input int from);
        start = s; resume = r;
        tick;
        start = 1'b0; resume = 1'b0;
        t0 = cyc;
        sb.push_back(model(from));
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int n;
        n = 0;
        while (!done && n < 40) begin
            tick;
            n++;
        end
        e = sb.pop_front();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_lat"}, cyc - t0, e.lat);
        chk({tag, "_sat"}, sat, e.sat);
        chk({tag, "_exh"}, exhausted, e.exh);
        chk({tag, "_asg"}, assignment, e.asg);
        chk({tag, "_busy"}, busy, 0);
        tick;
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_hold"}, sat, e.sat);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, wr_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sat"}, sat, 0);
        chk({tag, "_exh"}, exhausted, 0);
    endtask

    initial begin
        for (int c = 0; c < M; c++) begin
            mpos[c] = '0;
            mneg[c] = '0;
        end
        tick;
        tick;
        reset = 1'b0;
        tick;
        chk_idle("rst");
        chk("rst_asg", assignment, 0);

        // asynchronous reset in the middle of an unsatisfiable search
        write_clause(0, 4'b0001, 4'b0000);
        write_clause(1, 4'b0000, 4'b0001);
        start = 1'b1; tick; start = 1'b0;
        tick;
        tick;
        chk("mid_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk_idle("async_rst");
        chk("async_rst_asg", assignment, 0);
        for (int c = 0; c < M; c++) begin
            mpos[c] = '0;
            mneg[c] = '0;
        end
        #2 reset = 1'b0;
        tick;
        go(1'b1, 1'b0, 0);
        wait_done("empty");
        chk("empty_asg_const", assignment, 4'b0000);
        abort = 1'b1; tick; abort = 1'b0;
        chk_idle("abort_found");

        // three clauses: x0, ~x1, x2|x3
        write_clause(0, 4'b0001, 4'b0000);
        write_clause(1, 4'b0000, 4'b0010);
        write_clause(2, 4'b1100, 4'b0000);
        go(1'b1, 1'b0, 0);
        chk("first_busy", busy, 1);
        wait_done("first");
        chk("first_const", assignment, 4'b0101);
        go(1'b0, 1'b1, 6);
        wait_done("res1");
        chk("res1_const", assignment, 4'b1001);
        go(1'b0, 1'b1, 10);
        wait_done("res2");
        chk("res2_const", assignment, 4'b1101);
        go(1'b0, 1'b1, 14);
        wait_done("res3");
        chk("res3_exh_const", exhausted, 1);

        // x0 & ~x0
        write_clause(0, 4'b0001, 4'b0000);
        write_clause(1, 4'b0000, 4'b0001);
        write_clause(2, 4'b0000, 4'b0000);
        go(1'b1, 1'b0, 0);
        chk("unsat_busy", busy, 1);
        chk("unsat_exh_cleared", exhausted, 0);
        wait_done("unsat");
        chk("unsat_lat_const", cyc - t0 - 1, 16);

        // abort in the third search cycle; a write during search must be dropped
        write_clause(1, 4'b0000, 4'b0010);
        write_clause(2, 4'b1100, 4'b0000);
        start = 1'b1; tick; start = 1'b0;
        chk("abt_busy", busy, 1);
        wr_valid = 1'b1; wr_addr = 2'd3; wr_pos = 4'b0000; wr_neg = 4'b0001;
        chk("abt_ready", wr_ready, 0);
        tick;
        wr_valid = 1'b0;
        tick;
        abort = 1'b1; tick; abort = 1'b0;
        chk_idle("abt");
        tick;
        tick;
        chk("abt_no_done", done, 0);
        go(1'b1, 1'b0, 0);
        wait_done("after_drop");
        chk("after_drop_const", assignment, 4'b0101);

        // start wins over resume in FOUND
        go(1'b1, 1'b1, 0);
        wait_done("restart");
        chk("restart_const", assignment, 4'b0101);

        // write and start in the same IDLE cycle: the new clause is used from the first evaluation
        abort = 1'b1; tick; abort = 1'b0;
        mpos[3] = 4'b0000; mneg[3] = 4'b0001;
        wr_valid = 1'b1; wr_addr = 2'd3; wr_pos = 4'b0000; wr_neg = 4'b0001; start = 1'b1;
        tick;
        wr_valid = 1'b0; start = 1'b0;
        t0 = cyc;
        sb.push_back(model(0));
        wait_done("wr_start");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
